// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU ops,
// next-PC selects and the packed control bundle carried into EX.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU ops 0-7 share the value of their opcode; the byte loads get 8 and 9.
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_LLB    = 4'h8;
  localparam logic [3:0] ALU_LHB    = 4'h9;

  localparam logic [1:0] BR_SEQ  = 2'd0;
  localparam logic [1:0] BR_IMM  = 2'd1;
  localparam logic [1:0] BR_REG  = 2'd2;
  localparam logic [1:0] BR_HALT = 2'd3;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusext;
    logic       pcread;
    logic [1:0] branch;
    logic [3:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the control bundle and flags
// telling which register fields the instruction reads in ID.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       use_rs_o,
  output logic       use_rt_o,
  output logic       use_rd_o
);

  always_comb begin
    ctrl_o   = CTRL_NOP;
    use_rs_o = 1'b0;
    use_rt_o = 1'b0;
    use_rd_o = 1'b0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = opcode_i;
        use_rs_o        = 1'b1;
        use_rt_o        = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = opcode_i;
        use_rs_o        = 1'b1;
      end
      OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.aluop    = ALU_ADD;
        use_rs_o        = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.aluop    = ALU_ADD;
        use_rs_o        = 1'b1;
        use_rd_o        = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.alusext  = 1'b1;
        ctrl_o.aluop    = (opcode_i == OP_LLB) ? ALU_LLB : ALU_LHB;
        use_rs_o        = 1'b1;
        use_rd_o        = 1'b1;
      end
      OP_B:   ctrl_o.branch = BR_IMM;
      OP_BR: begin
        ctrl_o.branch = BR_REG;
        use_rs_o      = 1'b1;
      end
      OP_PCS: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.pcread   = 1'b1;
      end
      OP_HLT: ctrl_o.branch = BR_HALT;
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control register with load-use hazard detection, hold/flush
// priority, sticky halt and a saturating hazard-bubble counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               ext_stall,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_alusrc,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_alusext,
  output logic               ex_pcread,
  output logic [1:0]         ex_branch,
  output logic [3:0]         ex_aluop,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic               halted,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [3:0]        id_op;
  logic [REG_AW-1:0] id_rd, id_rs, id_rt;
  ctrl_t             id_ctrl;
  logic              use_rs, use_rt, use_rd;
  logic              src_hit, load_id, advance;

  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign id_op = id_instr[INSTR_W-1 -: 4];
  assign id_rd = id_instr[INSTR_W-5 -: REG_AW];
  assign id_rs = id_instr[INSTR_W-5-REG_AW -: REG_AW];
  assign id_rt = id_instr[INSTR_W-5-2*REG_AW -: REG_AW];

  ctrl_decode u_decode (
    .opcode_i (id_op),
    .ctrl_o   (id_ctrl),
    .use_rs_o (use_rs),
    .use_rt_o (use_rt),
    .use_rd_o (use_rd)
  );

  // Only a load already in EX can make its result late for the ID reader.
  assign src_hit = (use_rs && id_rs == ex_rd_q) ||
                   (use_rt && id_rt == ex_rd_q) ||
                   (use_rd && id_rd == ex_rd_q);
  assign hazard_stall = id_valid && ex_valid_q && ex_ctrl_q.memread &&
                        (ex_rd_q != '0) && src_hit && !halted_q;

  assign advance = !flush && !ext_stall;
  assign load_id = advance && id_valid && !halted_q && !hazard_stall;

  always_comb begin
    ex_ctrl_d  = ex_ctrl_q;
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    if (load_id) begin
      ex_ctrl_d  = id_ctrl;
      ex_valid_d = 1'b1;
      ex_rd_d    = id_rd;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
    end else if (flush || !ext_stall) begin
      ex_ctrl_d  = CTRL_NOP;
      ex_valid_d = 1'b0;
      ex_rd_d    = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
    end
  end

  assign halted_d = halted_q || (load_id && id_op == OP_HLT);
  assign cnt_d    = (advance && hazard_stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q  <= CTRL_NOP;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_memread  = ex_ctrl_q.memread;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_alusext  = ex_ctrl_q.alusext;
  assign ex_pcread   = ex_ctrl_q.pcread;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_aluop    = ex_ctrl_q.aluop;
  assign ex_rd       = ex_rd_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign halted      = halted_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a reference model predicts the EX register and
// counters each cycle; predictions queue up and are compared after the edge.
module tb_ctrl_pipe;

  localparam int CNT_W = 4;
  localparam int VW    = 1 + 13 + 12 + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [15:0]      id_instr = '0;
  logic             ext_stall = 1'b0;
  logic             flush = 1'b0;
  logic             hazard_stall;
  logic             ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite;
  logic             ex_memtoreg, ex_alusext, ex_pcread;
  logic [1:0]       ex_branch;
  logic [3:0]       ex_aluop;
  logic [3:0]       ex_rd, ex_rs, ex_rt;
  logic             halted;
  logic [CNT_W-1:0] bubble_cnt;

  ctrl_pipe #(.INSTR_W(16), .REG_AW(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .ext_stall    (ext_stall),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_alusrc    (ex_alusrc),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_memtoreg  (ex_memtoreg),
    .ex_alusext   (ex_alusext),
    .ex_pcread    (ex_pcread),
    .ex_branch    (ex_branch),
    .ex_aluop     (ex_aluop),
    .ex_rd        (ex_rd),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .halted       (halted),
    .bubble_cnt   (bubble_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [VW-1:0] exp_q[$];

  // model state
  logic             m_valid;
  logic [12:0]      m_ctrl;   // {rw,as,mr,mw,mtr,ase,pcr,br[1:0],aluop[3:0]}
  logic [3:0]       m_rd, m_rs, m_rt;
  logic             m_halted;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] ref_ctrl(input logic [3:0] op);
    case (op)
      4'h0: return 13'b1000000_00_0000;
      4'h1: return 13'b1000000_00_0001;
      4'h2: return 13'b1000000_00_0010;
      4'h3: return 13'b1000000_00_0011;
      4'h4: return 13'b1100000_00_0100;
      4'h5: return 13'b1100000_00_0101;
      4'h6: return 13'b1100000_00_0110;
      4'h7: return 13'b1000000_00_0111;
      4'h8: return 13'b1110100_00_0000;
      4'h9: return 13'b0101000_00_0000;
      4'hA: return 13'b1100010_00_1000;
      4'hB: return 13'b1100010_00_1001;
      4'hC: return 13'b0000000_01_0000;
      4'hD: return 13'b0000000_10_0000;
      4'hE: return 13'b1000001_00_0000;
      default: return 13'b0000000_11_0000;
    endcase
  endfunction

  function automatic logic ref_hazard(input logic v, input logic [15:0] ins);
    logic [3:0] op, rd, rs, rt;
    logic hit;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    hit = 1'b0;
    if ((op <= 4'hB || op == 4'hD) && rs == m_rd) hit = 1'b1;
    if ((op <= 4'h3 || op == 4'h7) && rt == m_rd) hit = 1'b1;
    if ((op == 4'h9 || op == 4'hA || op == 4'hB) && rd == m_rd) hit = 1'b1;
    // m_ctrl[10] is memread
    return v && m_valid && m_ctrl[10] && (m_rd != 4'd0) && hit && !m_halted;
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_rs = '0; m_rt = '0;
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [15:0] ins,
                            input logic es, input logic fl, input logic haz);
    if (!rst) begin
      model_bubble();
      m_halted = 1'b0;
      m_cnt    = '0;
    end else if (fl) begin
      model_bubble();
    end else if (es) begin
      // EX holds
    end else if (m_halted || haz || !v) begin
      model_bubble();
      if (haz && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_valid = 1'b1;
      m_ctrl  = ref_ctrl(ins[15:12]);
      m_rd = ins[11:8]; m_rs = ins[7:4]; m_rt = ins[3:0];
      if (ins[15:12] == 4'hF) m_halted = 1'b1;
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg,
            ex_alusext, ex_pcread, ex_branch, ex_aluop, ex_rd, ex_rs, ex_rt,
            halted, bubble_cnt};
  endfunction

  // driver: one cycle of stimulus, hazard check, prediction, post-edge compare
  task automatic step(input logic rst, input logic v, input logic [15:0] ins,
                      input logic es, input logic fl);
    logic haz;
    @(negedge clk);
    rst_n = rst; id_valid = v; id_instr = ins; ext_stall = es; flush = fl;
    #1;
    haz = ref_hazard(v, ins);
    check("hazard_stall", 64'(hazard_stall), 64'(haz));
    model_step(rst, v, ins, es, fl, haz);
    exp_q.push_back({m_valid, m_ctrl, m_rd, m_rs, m_rt, m_halted, m_cnt});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
    else check("ex_bundle", 64'(dut_vec()), 64'(exp_q.pop_front()));
  endtask

  task automatic run(input logic [15:0] ins);
    step(1'b1, 1'b1, ins, 1'b0, 1'b0);
  endtask

  initial begin
    m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_rs = '0; m_rt = '0;
    m_halted = 1'b0; m_cnt = '0;

    // reset state
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h8310, 1'b1, 1'b0);
    check("reset_valid", 64'(ex_valid), 64'd0);

    // back-to-back decode
    run(16'h0123);
    check("add_aluop", 64'(ex_aluop), 64'd0);
    run(16'hA5FF);
    check("llb_aluop", 64'(ex_aluop), 64'd8);
    check("llb_ctl", 64'({ex_alusrc, ex_alusext, ex_regwrite}), 64'b111);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // load-use hazard: LW r3 ; ADD r4,r3,r2 (held in ID by the stall)
    run(16'h8310);
    run(16'h0432);
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_cnt", 64'(bubble_cnt), 64'd1);
    run(16'h0432);
    check("lu_add", 64'({ex_valid, ex_rd}), 64'h14);

    // r0 destination never stalls
    run(16'h8010);
    run(16'h0402);
    check("r0_cnt", 64'(bubble_cnt), 64'd1);

    // ext_stall on a LW -> SW hazard
    run(16'h8520);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h9510, 1'b1, 1'b0);
    check("hold_lw", 64'({ex_valid, ex_memread, ex_rd}), 64'h35);
    check("hold_cnt", 64'(bubble_cnt), 64'd1);
    run(16'h9510);
    check("hold_bubble_cnt", 64'(bubble_cnt), 64'd2);
    run(16'h9510);

    // flush, flush over hold, flushed HLT
    step(1'b1, 1'b1, 16'hD300, 1'b0, 1'b1);
    check("flush_br", 64'(ex_valid), 64'd0);
    run(16'h0123);
    step(1'b1, 1'b1, 16'h0123, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'hF000, 1'b0, 1'b1);
    check("flush_hlt", 64'(halted), 64'd0);

    // halt and recovery
    run(16'hF000);
    check("halt_set", 64'({halted, ex_branch}), 64'h7);
    run(16'h0123);
    run(16'h8310);
    check("halt_bubble", 64'(ex_valid), 64'd0);
    step(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0);
    check("halt_reset", 64'({halted, bubble_cnt}), 64'd0);

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      run(16'h8310);
      run(16'h0432);
      run(16'h0432);
    end
    check("cnt_sat", 64'(bubble_cnt), 64'({CNT_W{1'b1}}));

    // constrained-random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic [15:0] ins;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h8;
      ins = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      step($urandom_range(0, 99) >= 3, $urandom_range(0, 9) != 0, ins,
           $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 16-bit CPU. It decodes the ID-stage instruction into the control bundle and registers that bundle into the ID/EX pipeline register. It detects load-use hazards and inserts one-cycle bubbles, honours downstream hold and branch flush, latches halt, and counts hazard bubbles. It sits between the IF/ID register and the execute stage, and drives the PC/IF-ID freeze.

## Interface
- `INSTR_W`, 16, instruction width. Opcode is `instr[INSTR_W-1 -: 4]`.
- `REG_AW`, 4, register address width. Fields below the opcode, MSB first: `rd`, `rs`, `rt`, each `REG_AW` bits. Requires `INSTR_W >= 4 + 3*REG_AW`.
- `CNT_W`, 16, width of the bubble counter.
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `rst_n`, in, 1, reset, synchronous, active-low.
- `id_valid`, in, 1, `id_instr` holds a real instruction.
- `id_instr`, in, `INSTR_W`, instruction in ID.
- `ext_stall`, in, 1, downstream hold (memory wait).
- `flush`, in, 1, branch taken; kill the ID instruction.
- `hazard_stall`, out, 1, combinational; freeze PC and IF/ID.
- `ex_valid`, out, 1, EX holds a real instruction.
- `ex_regwrite`, `ex_alusrc`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_alusext`, `ex_pcread`, out, 1 each, registered controls.
- `ex_branch`, out, 2, next-PC select: 0 = PC+2, 1 = PC+2+imm, 2 = rs, 3 = halt.
- `ex_aluop`, out, 4, ALU operation.
- `ex_rd`, `ex_rs`, `ex_rt`, out, `REG_AW` each, registered fields.
- `halted`, out, 1, sticky halt.
- `bubble_cnt`, out, `CNT_W`, saturating count of hazard bubbles.

## Operation
- **Opcodes.** 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
- **Decode.**
  - `regwrite`: ops 0–8, A, B, E.
  - `alusrc`: ops 4, 5, 6, 8, 9, A, B.
  - `memread` = `memtoreg`: op 8.
  - `memwrite`: op 9.
  - `alusext`: ops A, B.
  - `pcread`: op E.
  - `branch`: C→1, D→2, F→3, else 0.
  - `aluop`: ops 0–7 map to themselves; 8 and 9 → 0; A → 8; B → 9; all others → 0. No X values are ever produced.
- **Sources read by ID.**
  - `rs`: ops 0–9, A, B, D.
  - `rt`: ops 0, 1, 2, 3, 7.
  - `rd` field as a source: ops 9, A, B.
- **Hazard.** `hazard_stall` = `id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd` equals any used source of the ID instruction`)`, and is forced to 0 while `halted`. Register 0 never causes a hazard.
- **ID/EX update priority, per edge:**
  1. Reset: all outputs 0.
  2. `flush`: bubble.
  3. `ext_stall`: hold all EX outputs.
  4. `halted` or `hazard_stall` or `!id_valid`: bubble.
  5. Otherwise: load the decoded bundle and fields, and set `ex_valid`=1.
- **Bubble.** `ex_valid` and every control bit are 0. The field registers hold don't-care values, which are driven to 0.
- **Halt.** `halted` is set at the same edge a HLT is loaded into EX, and stays set until reset. After that, ID is never loaded.
- **Counter.** `bubble_cnt` increments by 1 at each edge where case 4 applies because of `hazard_stall`. It saturates at all-ones and is cleared by reset.

## Timing
- Decode to EX: 1-cycle latency. `hazard_stall` has zero latency (combinational from `id_instr` and EX regs).
- A load-use pair produces exactly one bubble. Once the bubble is in EX, `ex_memread`=0, so `hazard_stall` drops.
- `ext_stall` and hazard in the same cycle: EX holds, `hazard_stall` stays asserted, and the counter does not increment.
- `flush` and `ext_stall` in the same cycle: flush wins.
- `flush` on a HLT in ID: HLT is killed and `halted` stays 0.
- `rst_n` low in the middle of a stall or halt: all state returns to reset values at the next edge.

## Structure
- **Package `ctrl_pkg`:**
  - opcode localparams (`OP_ADD`..`OP_HLT`);
  - `aluop` encodings;
  - `branch` encodings (`BR_SEQ`, `BR_IMM`, `BR_REG`, `BR_HALT`);
  - packed struct `ctrl_t` for the control bundle.
- **Sub-module `ctrl_decode`:** purely combinational opcode → `ctrl_t` plus source-use flags. It is instantiated once; `ctrl_pipe` owns all sequential logic.

## Test plan
- **Back-to-back decode.** ADD (0x0123) then LLB (0xA5FF), no stalls → `ex_aluop`=0 then 8. The LLB cycle shows `alusrc`=1, `alusext`=1, `regwrite`=1.
- **Load-use hazard.** LW r3 then ADD r4,r3,r2 → `hazard_stall`=1 for one cycle, one bubble (`ex_valid`=0), `bubble_cnt`=1, then ADD loads.
- **r0 destination.** LW r0 then ADD r4,r0,r2 → no stall, `bubble_cnt` stays 0.
- **ext_stall with hazard.** `ext_stall` for 3 cycles during a LW→SW hazard → EX holds LW for 3 cycles, counter unchanged. Exactly one bubble follows release.
- **Flush.** `flush` asserted with BR in ID → EX bubble. HLT followed by flush → `halted`=0.
- **Halt.** HLT loaded → `halted`=1 and `ex_branch`=3. Subsequent IDs produce bubbles. `rst_n`=0 for one edge clears `halted` and `bubble_cnt`.
